// File: rtl/fft_frame_sequencer_if.sv
// Bundles the frame sequencer's sample-load, stage-control and result-unload signals.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on load and out_valid/out_ready on unload; stage_done completes each stage.
interface fft_frame_sequencer_if #(
    parameter int NUMSTAGES = 5
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 load_we;
    logic [NUMSTAGES-1:0] load_addr;
    logic                 en_r;
    logic [2:0]           stage_num_r;
    logic                 stage_done;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUMSTAGES-1:0] out_addr;
    logic                 busy;
    logic                 frame_done;

    // Sequencer side
    modport master (
        input  start, in_valid, stage_done, out_ready,
        output in_ready, load_we, load_addr, en_r, stage_num_r,
               out_valid, out_addr, busy, frame_done
    );

    // Environment side: sample source, stage controller, result sink
    modport slave (
        output start, in_valid, stage_done, out_ready,
        input  in_ready, load_we, load_addr, en_r, stage_num_r,
               out_valid, out_addr, busy, frame_done
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller: bit-reversed load, stage-by-stage FFT run with a one-cycle gap between stages, natural-order unload.
// Latency: load writes combinationally in the accept cycle; all control outputs are registered, one cycle after the causing edge.
// Backpressure: in_valid gates load progress, stage_done gates each stage, out_ready stalls unload; start is ignored while busy.
module fft_frame_sequencer #(
    parameter int NUMSTAGES  = 5,
    parameter int NUMSAMPLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_UNLOAD
    } state_t;

    localparam logic [NUMSTAGES:0]   LAST_CNT   = (NUMSTAGES+1)'(NUMSAMPLES-1);
    localparam logic [NUMSTAGES-1:0] LAST_ADDR  = NUMSTAGES'(NUMSAMPLES-1);
    localparam logic [2:0]           LAST_STAGE = 3'(NUMSTAGES-1);

    state_t               state_q, state_d;
    logic [NUMSTAGES:0]   cnt_q, cnt_d;
    logic [2:0]           stage_q, stage_d;
    logic                 en_q, en_d;
    logic [NUMSTAGES-1:0] out_addr_q, out_addr_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic                 in_ready_c;
    logic                 load_we_c;
    logic [NUMSTAGES-1:0] load_addr_c;

    // Load side is combinational so a sample is written in the cycle it is accepted.
    assign in_ready_c = (state_q == S_LOAD);
    assign load_we_c  = in_ready_c && bus.in_valid;

    // Write address is the bit-reversed sample count, so memory holds the frame in butterfly order.
    always_comb begin
        load_addr_c = '0;
        for (int i = 0; i < NUMSTAGES; i++) begin
            load_addr_c[i] = cnt_q[NUMSTAGES-1-i];
        end
    end

    // Next-state and counter updates; stage_done only counts while the stage is enabled.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        en_d         = en_q;
        out_addr_d   = out_addr_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (load_we_c) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_RUN;
                        stage_d = '0;
                        en_d    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (en_q && bus.stage_done) begin
                    en_d    = 1'b0;
                    stage_d = stage_q + 1'b1;
                    if (stage_q == LAST_STAGE) begin
                        state_d    = S_UNLOAD;
                        out_addr_d = '0;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // One idle cycle lets the stage controller reset its counters.
                state_d = S_RUN;
                en_d    = 1'b1;
            end
            S_UNLOAD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_addr_d = out_addr_q + 1'b1;
                    if (out_addr_q == LAST_ADDR) begin
                        frame_done_d = 1'b1;
                        stage_d      = '0;
                        out_addr_d   = '0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_UNLOAD);
    end

    // State and registered outputs, synchronous reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stage_q      <= '0;
            en_q         <= 1'b0;
            out_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            en_q         <= en_d;
            out_addr_q   <= out_addr_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.load_we     = load_we_c;
    assign bus.load_addr   = load_addr_c;
    assign bus.en_r        = en_q;
    assign bus.stage_num_r = stage_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
endmodule
